img_loader: RTL

Streams a raw 24-bit RGB image into the frame memory. Bytes arrive from the host link (UART receiver or similar) over a valid/ready byte interface; the block packs each R,G,B triple into one pixel and writes it into the memory write port at `IMG_WIDTH*y + x`. This is the same raster address mapping used by the display-side readers, so a loaded frame is immediately visible to the threshold/display path.

---
 rtl/img_pkg.sv | 22 ++
 rtl/rgb_packer.sv | 43 ++++
 rtl/img_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared types and constants for the frame loader: pixel layout, FSM states
// and the byte positions inside one RGB triple.
package img_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam logic [1:0] BYTE_R = 2'd0;
  localparam logic [1:0] BYTE_G = 2'd1;
  localparam logic [1:0] BYTE_B = 2'd2;

endpackage

// File: rtl/rgb_packer.sv
// Gathers an R,G,B byte sequence into one 24-bit pixel. The pixel is flagged
// in the same cycle the blue byte is accepted; blue is forwarded directly.
module rgb_packer
  import img_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [23:0] pix_o,
  output logic        pix_valid_o
);

  logic [1:0] idx_q, idx_d;
  logic [7:0] r_q, g_q;
  pixel_t     pix;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = BYTE_R;
    end else if (accept_i) begin
      idx_d = (idx_q == BYTE_B) ? BYTE_R : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= BYTE_R;
    else        idx_q <= idx_d;
  end

  // Colour bytes carry no control meaning, so they are left out of reset.
  always_ff @(posedge clk) begin
    if (accept_i && idx_q == BYTE_R) r_q <= byte_i;
    if (accept_i && idx_q == BYTE_G) g_q <= byte_i;
  end

  assign pix         = '{r: r_q, g: g_q, b: byte_i};
  assign pix_o       = pix;
  assign pix_valid_o = accept_i && (idx_q == BYTE_B);

endmodule

// File: rtl/img_loader.sv
// Streams raw RGB bytes into frame memory in raster order, one registered
// write per pixel at address IMG_WIDTH*y + x.
module img_loader
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  loader_state_t     state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;

  logic              accept;
  logic [23:0]       pix;
  logic              pix_valid;
  logic [ADDR_W-1:0] addr_cur;

  assign accept = in_valid && (state_q == COLLECT);

  // Byte index is forced back to R whenever no collection is underway.
  rgb_packer u_packer (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (state_q != COLLECT),
    .accept_i    (accept),
    .byte_i      (in_data),
    .pix_o       (pix),
    .pix_valid_o (pix_valid)
  );

  // Widen before multiplying so the product never truncates.
  assign addr_cur = ADDR_W'(y_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x_q);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        if (pix_valid) begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_cur;
          wr_data_d = pix;
        end
      end
      WRITE: begin
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready = (state_q == COLLECT);
  assign busy     = (state_q == COLLECT) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
